e_cpu_ci_issuer: RTL

E_CPU_CI_ISSUER -- requirements
Module: e_cpu_ci_issuer

---
 rtl/e_cpu_ci_issuer_if.sv | 42 ++++
 rtl/e_cpu_ci_issuer.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/e_cpu_ci_issuer_if.sv
// Bus bundle between a CPU custom-instruction port, the issuer and the
// east-edge fabric IO tiles.
//   cmd_*  : CPU request handshake, operands and per-op fabric configuration
//   OPA_O/OPB_O : operands presented to the fabric
//   RES*_I : fabric results; RES2_I[0] is the fabric done flag
//   rsp_*  : response handshake and captured results back to the CPU
// The slave modport is the issuer; master is the CPU/fabric environment.
interface e_cpu_ci_issuer_if #(
  parameter int WIDTH = 32
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_op_a;
  logic [WIDTH-1:0] cmd_op_b;
  logic [3:0]       cfg_latency;
  logic             cfg_use_done;
  logic [WIDTH-1:0] OPA_O;
  logic [WIDTH-1:0] OPB_O;
  logic [WIDTH-1:0] RES0_I;
  logic [WIDTH-1:0] RES1_I;
  logic [WIDTH-1:0] RES2_I;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_res0;
  logic [WIDTH-1:0] rsp_res1;
  logic [WIDTH-1:0] rsp_status;
  logic             rsp_timeout;

  modport slave (
    input  cmd_valid, cmd_op_a, cmd_op_b, cfg_latency, cfg_use_done,
    input  RES0_I, RES1_I, RES2_I, rsp_ready,
    output cmd_ready, OPA_O, OPB_O, rsp_valid, rsp_res0, rsp_res1,
    output rsp_status, rsp_timeout
  );

  modport master (
    output cmd_valid, cmd_op_a, cmd_op_b, cfg_latency, cfg_use_done,
    output RES0_I, RES1_I, RES2_I, rsp_ready,
    input  cmd_ready, OPA_O, OPB_O, rsp_valid, rsp_res0, rsp_res1,
    input  rsp_status, rsp_timeout
  );
endinterface

// File: rtl/e_cpu_ci_issuer.sv
// Custom-instruction issuer: accepts one CPU request at a time, drives the
// operands into the FPGA fabric, waits either a fixed latency or for the
// fabric done flag (with timeout), captures the three fabric result words
// and holds them as a response until the CPU takes it.
// Ports:
//   UserCLK : clock, all state updates on the rising edge
//   reset   : synchronous, active-high
//   bus     : e_cpu_ci_issuer_if.slave (command, fabric and response signals)
module e_cpu_ci_issuer #(
  parameter int WIDTH      = 32,
  parameter int TMO_CYCLES = 255
) (
  input  logic               UserCLK,
  input  logic               reset,
  e_cpu_ci_issuer_if.slave   bus
);

  localparam int CW_NEED = $clog2(TMO_CYCLES + 1);
  localparam int CW      = (CW_NEED > 8) ? CW_NEED : 8;
  localparam logic [CW-1:0] TMO_C = CW'(TMO_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       lat_q, lat_d;
  logic             use_done_q, use_done_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] res0_q, res0_d;
  logic [WIDTH-1:0] res1_q, res1_d;
  logic [WIDTH-1:0] status_q, status_d;
  logic             timeout_q, timeout_d;

  logic [CW-1:0]    cnt_inc;
  logic [CW-1:0]    lat_ext;
  logic             capture;
  logic             tmo_hit;

  assign lat_ext = CW'(lat_q);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lat_d      = lat_q;
    use_done_d = use_done_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    res0_d     = res0_q;
    res1_d     = res1_q;
    status_d   = status_q;
    timeout_d  = timeout_q;
    capture    = 1'b0;
    tmo_hit    = 1'b0;
    // cnt_inc is the number of WAIT cycles elapsed including the current one;
    // it sticks at all-ones instead of wrapping.
    cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          opa_d      = bus.cmd_op_a;
          opb_d      = bus.cmd_op_b;
          lat_d      = bus.cfg_latency;
          use_done_d = bus.cfg_use_done;
          state_d    = S_SETTLE;
        end
      end
      S_SETTLE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Done wins over a timeout in the same cycle. Latency 0 satisfies
        // the compare on the first WAIT cycle, same as latency 1.
        if (use_done_q) begin
          if (bus.RES2_I[0]) begin
            capture = 1'b1;
          end else if (cnt_inc >= TMO_C) begin
            capture = 1'b1;
            tmo_hit = 1'b1;
          end
        end else if (cnt_inc >= lat_ext) begin
          capture = 1'b1;
        end
        cnt_d = cnt_inc;
        if (capture) begin
          res0_d    = bus.RES0_I;
          res1_d    = bus.RES1_I;
          status_d  = bus.RES2_I;
          timeout_d = tmo_hit;
          state_d   = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge UserCLK) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      lat_q      <= '0;
      use_done_q <= 1'b0;
      opa_q      <= '0;
      opb_q      <= '0;
      res0_q     <= '0;
      res1_q     <= '0;
      status_q   <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lat_q      <= lat_d;
      use_done_q <= use_done_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      res0_q     <= res0_d;
      res1_q     <= res1_d;
      status_q   <= status_d;
      timeout_q  <= timeout_d;
    end
  end

  // Gated with reset so the CPU never sees ready while reset is held.
  assign bus.cmd_ready   = (state_q == S_IDLE) && !reset;
  assign bus.rsp_valid   = (state_q == S_RESP);
  assign bus.OPA_O       = opa_q;
  assign bus.OPB_O       = opb_q;
  assign bus.rsp_res0    = res0_q;
  assign bus.rsp_res1    = res1_q;
  assign bus.rsp_status  = status_q;
  assign bus.rsp_timeout = timeout_q;

endmodule
